// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte producers.
// A winner is picked in IDLE, its byte is latched and acked in GRANT, and
// START issues a single tx_start once uart_tx is free. WAIT then holds
// tx_din until tx_done, or until the optional watchdog aborts the byte.
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority, where
// channel 0 always wins. The default build uses round-robin.
//
// Handshake: req[i] is a level held with req_data[i] stable until ack[i]
// pulses for one cycle. ack[i] means the byte has been latched, and the
// producer may drop req[i] on the next cycle. done[i] pulses for one cycle
// once uart_tx reports tx_done for that byte. If req[i] drops before ack,
// the request is withdrawn silently.
module uart_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   done,
  output logic               tx_start,
  output logic [7:0]         tx_din,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               err_tmo,
  output logic [1:0]         state_dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};
  localparam logic [PW-1:0] LAST_CH  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   win, win_n;
  logic [PW-1:0]   rr_ptr, rr_n, rr_adv;
  logic [TW-1:0]   tmo_cnt, cnt_n;
  logic [N_REQ-1:0] ack_n, done_n;
  logic            start_n, err_n, found;
  logic [7:0]      din_n;
  logic [PW-1:0]   sel;
  int              idx;

  assign state_dbg = state;

  // Next-state, winner selection and next values of all registered outputs
  always_comb begin
    state_n = state;
    win_n   = win;
    rr_n    = rr_ptr;
    cnt_n   = tmo_cnt;
    din_n   = tx_din;
    err_n   = err_tmo;
    ack_n   = '0;
    done_n  = '0;
    start_n = 1'b0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    rr_adv  = '0;
`else
    rr_adv  = (win == LAST_CH) ? '0 : win + 1'b1;
`endif
    case (state)
      S_IDLE: begin
        for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (int'(rr_ptr) + k) % N_REQ;
`endif
          sel = PW'(idx);
          if (!found && req[sel]) begin
            found = 1'b1;
            win_n = sel;
          end
        end
        if (found) state_n = S_GRANT;
      end
      S_GRANT: begin
        // The winner may have withdrawn since IDLE sampled it
        if (req[win]) begin
          ack_n[win] = 1'b1;
          din_n      = req_data[8*win +: 8];
          state_n    = S_START;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (!tx_busy) begin
          start_n = 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          done_n[win] = 1'b1;
          rr_n        = rr_adv;
          state_n     = S_IDLE;
        end else if (TIMEOUT_CYC != 0 && tmo_cnt == TMO_LAST) begin
          err_n   = 1'b1;
          rr_n    = rr_adv;
          state_n = S_IDLE;
        end else if (tmo_cnt != TMO_MAX) begin
          cnt_n = tmo_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any byte in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      win      <= '0;
      rr_ptr   <= '0;
      tmo_cnt  <= '0;
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      tx_din   <= 8'h00;
      err_tmo  <= 1'b0;
    end else begin
      state    <= state_n;
      win      <= win_n;
      rr_ptr   <= rr_n;
      tmo_cnt  <= cnt_n;
      ack      <= ack_n;
      done     <= done_n;
      tx_start <= start_n;
      tx_din   <= din_n;
      err_tmo  <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=2, TIMEOUT_CYC=100).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  ack, done;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic        err_tmo;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .tx_start(tx_start), .tx_din(tx_din),
    .tx_busy(tx_busy), .tx_done(tx_done), .err_tmo(err_tmo),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // overall time limit
  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish, required finish before 200000");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One complete transfer starting from IDLE; req must already be driven.
  task automatic serve(input logic [1:0] oh, input logic [7:0] b, input bit drop, input string tag);
    tick();
    chk({tag, "_grant_noack"}, 32'(ack), 32'(0));
    chk({tag, "_grant_state"}, 32'(state_dbg), 32'(1));
    tick();
    chk({tag, "_ack"}, 32'(ack), 32'(oh));
    chk({tag, "_din_latch"}, 32'(tx_din), 32'(b));
    chk({tag, "_nostart_at_ack"}, 32'(tx_start), 32'(0));
    if (drop) req = req & ~oh;
    tick();
    chk({tag, "_start"}, 32'(tx_start), 32'(1));
    chk({tag, "_ack_cleared"}, 32'(ack), 32'(0));
    chk({tag, "_din_at_start"}, 32'(tx_din), 32'(b));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'(oh));
    chk({tag, "_start_single"}, 32'(tx_start), 32'(0));
  endtask

  initial begin
    // reset values
    tick();
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_din", 32'(tx_din), 32'(0));
    chk("rst_err_tmo", 32'(err_tmo), 32'(0));
    chk("rst_state", 32'(state_dbg), 32'(0));
    tick();
    rst = 1'b1;

    // single request on channel 0
    req_data = {8'h00, 8'h41};
    req = 2'b01;
    serve(2'b01, 8'h41, 1'b1, "single");
    tick();
    chk("single_done_pulse", 32'(done), 32'(0));
    chk("single_idle", 32'(state_dbg), 32'(0));

    // withdrawal before ack: no ack, back to IDLE
    req_data = {8'h00, 8'h55};
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    chk("withdraw_noack", 32'(ack), 32'(0));
    chk("withdraw_idle", 32'(state_dbg), 32'(0));
    tick();
    chk("withdraw_nostart", 32'(tx_start), 32'(0));

`ifdef UART_ARB_FIXED_PRIO_EN
    // fixed priority: channel 0 keeps winning while it requests
    do_reset();
    req_data = {8'h31, 8'h30};
    req = 2'b11;
    serve(2'b01, 8'h30, 1'b0, "prio_a");
    serve(2'b01, 8'h30, 1'b0, "prio_b");
    req = 2'b10;
    serve(2'b10, 8'h31, 1'b1, "prio_c");
`else
    // round-robin contention from reset: 30,31,30,31
    do_reset();
    req_data = {8'h31, 8'h30};
    req = 2'b11;
    serve(2'b01, 8'h30, 1'b0, "rr_a");
    serve(2'b10, 8'h31, 1'b0, "rr_b");
    serve(2'b01, 8'h30, 1'b0, "rr_c");
    serve(2'b10, 8'h31, 1'b0, "rr_d");
    req = 2'b00;
`endif
    tick();

    // busy hold at START for 50 cycles
    req_data = {8'h00, 8'h5a};
    tx_busy = 1'b1;
    req = 2'b01;
    tick();
    tick();
    chk("busy_ack", 32'(ack), 32'(2'b01));
    req = 2'b00;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("busy_nostart", 32'(tx_start), 32'(0));
      chk("busy_din_stable", 32'(tx_din), 32'(8'h5a));
    end
    chk("busy_state_start", 32'(state_dbg), 32'(2));
    tx_busy = 1'b0;
    tick();
    chk("busy_start", 32'(tx_start), 32'(1));
    chk("busy_din", 32'(tx_din), 32'(8'h5a));
    tick();
    chk("busy_start_single", 32'(tx_start), 32'(0));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("busy_done", 32'(done), 32'(2'b01));

    // watchdog: tx_done never arrives
    req_data = {8'hc3, 8'h00};
    req = 2'b10;
    tick();
    tick();
    chk("tmo_ack", 32'(ack), 32'(2'b10));
    req = 2'b00;
    tick();
    chk("tmo_start", 32'(tx_start), 32'(1));
    for (int i = 0; i < 99; i++) tick();
    chk("tmo_not_yet", 32'(err_tmo), 32'(0));
    chk("tmo_still_wait", 32'(state_dbg), 32'(3));
    tick();
    chk("tmo_err", 32'(err_tmo), 32'(1));
    chk("tmo_no_done", 32'(done), 32'(0));
    chk("tmo_idle", 32'(state_dbg), 32'(0));
    // tx_done outside WAIT is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("stray_done_ignored", 32'(done), 32'(0));
    // next request still served, error stays sticky
    req_data = {8'h00, 8'h77};
    req = 2'b01;
    serve(2'b01, 8'h77, 1'b1, "after_tmo");
    chk("tmo_sticky", 32'(err_tmo), 32'(1));
    tick();

    // reset in WAIT: outputs clear immediately, channel 1 served afterwards
    req_data = {8'he1, 8'h00};
    req = 2'b10;
    tick();
    tick();
    chk("rstwait_ack", 32'(ack), 32'(2'b10));
    tick();
    chk("rstwait_start", 32'(tx_start), 32'(1));
    tick();
    chk("rstwait_in_wait", 32'(state_dbg), 32'(3));
    rst = 1'b0;
    #1;
    chk("rstwait_tx_din", 32'(tx_din), 32'(0));
    chk("rstwait_err", 32'(err_tmo), 32'(0));
    chk("rstwait_ack0", 32'(ack), 32'(0));
    chk("rstwait_done0", 32'(done), 32'(0));
    chk("rstwait_state", 32'(state_dbg), 32'(0));
    tick();
    rst = 1'b1;
    serve(2'b10, 8'he1, 1'b1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
